bram_tdp_ram_be: RTL and testbench
==================================

Name: bram_tdp_ram_be

Overview:
- Single-clock true dual-port block RAM: two independent read/write ports A and B.
- Adds per-byte write enables, a per-port write mode, and a configurable read pipeline with a valid strobe.
- Resolves and flags same-address write collisions between the ports.
- Used as shared sample/coefficient storage between DSP datapaths and the register/AXI side, in the single fabric clock domain.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
- MEM_DEPTH, 1024, number of words; at most 2^ADDR_WIDTH.
- ADDR_WIDTH, 10, address width.
- RD_LATENCY, 1, cycles from read request to data; legal values 1..3.
- WRITE_MODE_A, 0, port A mode: 0 read-first, 1 write-first, 2 no-change.
- WRITE_MODE_B, 0, port B mode; same encoding as WRITE_MODE_A.

Ports:
- clk_a  in  1  single clock for both ports
- reset  in  1  synchronous, active-high
- en_a  in  1  port A access enable
- we_a  in  NB  port A byte write enables; ignored when en_a=0
- addr_a  in  ADDR_WIDTH  port A address
- wr_data_a  in  DATA_WIDTH  port A write data
- rd_data_a  out  DATA_WIDTH  port A read data
- rd_valid_a  out  1  port A read data valid
- en_b, we_b, addr_b, wr_data_b, rd_data_b, rd_valid_b: same as the port A signals, for port B
- collision  out  1  same-address write collision flag

Behaviour:
- Reset:
  - rd_data_a/b=0, rd_valid_a/b=0, collision=0; all read-pipeline stages cleared.
  - Memory contents are not cleared.
  - While reset is high, requests are ignored and no writes occur.
- Access: a port issues an access when en_x=1 in the cycle.
- Write:
  - Byte lane i of bram[addr_x] takes wr_data_x[i*BYTE_WIDTH +: BYTE_WIDTH] when we_x[i]=1.
  - Unselected lanes keep their contents.
- Read latency:
  - Every access (read or write) produces a read result after exactly RD_LATENCY cycles.
  - At that point rd_valid_x=1 for one cycle and rd_data_x is updated.
  - The pipeline is fully pipelined: one access per cycle per port, no stalls.
- Read data by write mode:
  - Read-first: returns the pre-write word.
  - Write-first: returns the post-write word (merged byte lanes).
  - No-change, access with any we_x bit set: rd_valid_x still pulses, and rd_data_x holds its previous value.
- Pure read (we_x=0): returns the current word in all modes.
- rd_data_x holds its last value when no result is delivered.
- Out-of-range address (addr >= MEM_DEPTH): the write is dropped, the read returns 0, and rd_valid still pulses.
- Cross-port read/write, same address, same cycle, port B reading while port A writes (and vice versa): the reader gets the OLD word, regardless of its own mode.
- Same-address write collision:
  - Condition: both ports write the same address with overlapping byte enables in the same cycle.
  - Port A wins on overlapping lanes.
  - Non-overlapping lanes from each port are both written.
  - collision pulses high for one cycle, 1 cycle after the request, independent of RD_LATENCY.
  - Disjoint byte enables at the same address set no collision.
- Reset during operation: in-flight pipeline results are discarded, and no rd_valid is asserted for requests issued before or during reset.
- Address/data inputs are sampled only on clk_a rising edges with en_x=1.

Test Plan:
- Reset, then A writes 0xDEADBEEF to addr 5 (we_a=0xF), then A reads addr 5 with RD_LATENCY=2 -> rd_valid_a high exactly 2 cycles after the read and rd_data_a=0xDEADBEEF; B reads addr 5 -> 0xDEADBEEF.
- Addr 7 holds 0x11223344; A writes 0xAABBCCDD with we_a=0x5 -> subsequent read returns 0x11BB33DD.
- Mode checks, addr 3 holds 0x0 and A writes 0x55 in one access:
  - WRITE_MODE_A=0 returns 0x0.
  - WRITE_MODE_A=1 returns 0x55.
  - WRITE_MODE_A=2: rd_data_a keeps its prior value 0xCAFE and rd_valid_a pulses.
- Same-cycle writes to addr 9, A=0x000000AA we_a=0x1 and B=0x0000BB00 we_b=0x3 -> collision pulses for 1 cycle and memory reads 0x0000BBAA.
- Back-to-back reads on both ports, addrs 0..15, every cycle, with random concurrent non-colliding writes -> each result matches the reference model, one per cycle, with RD_LATENCY=1 and RD_LATENCY=3.
- Assert reset 1 cycle after issuing 3 reads with RD_LATENCY=3 -> no rd_valid pulses, outputs 0; memory contents unchanged afterwards.

Source files
------------

// File: rtl/bram_tdp_ram_be.sv
// True dual-port block RAM, single clock, with per-byte write enables,
// a per-port write mode, a configurable read pipeline with valid strobe,
// and detection of same-address write collisions (port A wins overlaps).
module bram_tdp_ram_be #(
    parameter int DATA_WIDTH   = 32,
    parameter int BYTE_WIDTH   = 8,
    parameter int MEM_DEPTH    = 1024,
    parameter int ADDR_WIDTH   = 10,
    parameter int RD_LATENCY   = 1,
    parameter int WRITE_MODE_A = 0,
    parameter int WRITE_MODE_B = 0
) (
    input  logic                               clk_a,
    input  logic                               reset,
    input  logic                               en_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   we_a,
    input  logic [ADDR_WIDTH-1:0]              addr_a,
    input  logic [DATA_WIDTH-1:0]              wr_data_a,
    output logic [DATA_WIDTH-1:0]              rd_data_a,
    output logic                               rd_valid_a,
    input  logic                               en_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   we_b,
    input  logic [ADDR_WIDTH-1:0]              addr_b,
    input  logic [DATA_WIDTH-1:0]              wr_data_b,
    output logic [DATA_WIDTH-1:0]              rd_data_b,
    output logic                               rd_valid_b,
    output logic                               collision
);

    localparam int NB               = DATA_WIDTH / BYTE_WIDTH;
    localparam int MODE_WRITE_FIRST = 1;
    localparam int MODE_NO_CHANGE   = 2;

    // One read result travelling down the pipeline; keep means "pulse valid
    // but leave rd_data untouched" (no-change mode write).
    typedef struct packed {
        logic                  valid;
        logic                  keep;
        logic [DATA_WIDTH-1:0] data;
    } rd_slot_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  range_a_s;
    logic                  range_b_s;
    logic [DATA_WIDTH-1:0] old_a_s;
    logic [DATA_WIDTH-1:0] old_b_s;
    rd_slot_t              req_a_s;
    rd_slot_t              req_b_s;
    rd_slot_t              tap_a_s;
    rd_slot_t              tap_b_s;
    logic                  collision_s;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (32'(addr) < 32'(MEM_DEPTH));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NB-1:0]         be
    );
        logic [DATA_WIDTH-1:0] result;
        result = old_word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                result[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                result[i*BYTE_WIDTH +: BYTE_WIDTH] = old_word[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return result;
    endfunction

    // Fetch the pre-write word of each port; out-of-range addresses read as zero.
    always_comb begin
        range_a_s = in_range(addr_a);
        range_b_s = in_range(addr_b);
        old_a_s   = '0;
        old_b_s   = '0;
        if (range_a_s) begin
            old_a_s = mem[addr_a];
        end else begin
            old_a_s = '0;
        end
        if (range_b_s) begin
            old_b_s = mem[addr_b];
        end else begin
            old_b_s = '0;
        end
    end

    // Form each port's read result from its write mode (cross-port writes are never visible).
    always_comb begin
        req_a_s       = '0;
        req_b_s       = '0;
        req_a_s.valid = en_a;
        req_b_s.valid = en_b;
        if (WRITE_MODE_A == MODE_NO_CHANGE) begin
            req_a_s.keep = |we_a;
        end else begin
            req_a_s.keep = 1'b0;
        end
        if (WRITE_MODE_B == MODE_NO_CHANGE) begin
            req_b_s.keep = |we_b;
        end else begin
            req_b_s.keep = 1'b0;
        end
        if (!range_a_s) begin
            req_a_s.data = '0;
        end else if (WRITE_MODE_A == MODE_WRITE_FIRST) begin
            req_a_s.data = merge_bytes(old_a_s, wr_data_a, we_a);
        end else begin
            req_a_s.data = old_a_s;
        end
        if (!range_b_s) begin
            req_b_s.data = '0;
        end else if (WRITE_MODE_B == MODE_WRITE_FIRST) begin
            req_b_s.data = merge_bytes(old_b_s, wr_data_b, we_b);
        end else begin
            req_b_s.data = old_b_s;
        end
    end

    // Byte-lane writes; port A is applied last so it owns overlapping lanes.
    always_ff @(posedge clk_a) begin
        if (!reset) begin
            for (int i = 0; i < NB; i++) begin
                if (en_b && range_b_s && we_b[i]) begin
                    mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
            for (int i = 0; i < NB; i++) begin
                if (en_a && range_a_s && we_a[i]) begin
                    mem[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Overlapping byte enables on the same in-range address raise a collision.
    always_comb begin
        collision_s = en_a && en_b && range_a_s && (addr_a == addr_b) && (|(we_a & we_b));
    end

    // Collision flag is a one-cycle registered pulse regardless of read latency.
    always_ff @(posedge clk_a) begin
        if (reset) begin
            collision <= 1'b0;
        end else begin
            collision <= collision_s;
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_direct
            assign tap_a_s = req_a_s;
            assign tap_b_s = req_b_s;
        end else begin : g_pipe
            rd_slot_t pipe_a_r [RD_LATENCY-1];
            rd_slot_t pipe_b_r [RD_LATENCY-1];

            // Delay line for read results; reset drops everything in flight.
            always_ff @(posedge clk_a) begin
                if (reset) begin
                    for (int i = 0; i < RD_LATENCY - 1; i++) begin
                        pipe_a_r[i] <= '0;
                        pipe_b_r[i] <= '0;
                    end
                end else begin
                    pipe_a_r[0] <= req_a_s;
                    pipe_b_r[0] <= req_b_s;
                    for (int i = 1; i < RD_LATENCY - 1; i++) begin
                        pipe_a_r[i] <= pipe_a_r[i-1];
                        pipe_b_r[i] <= pipe_b_r[i-1];
                    end
                end
            end

            assign tap_a_s = pipe_a_r[RD_LATENCY-2];
            assign tap_b_s = pipe_b_r[RD_LATENCY-2];
        end
    endgenerate

    // Output stage: pulse valid per delivered result, hold data unless updated.
    always_ff @(posedge clk_a) begin
        if (reset) begin
            rd_data_a  <= '0;
            rd_valid_a <= 1'b0;
            rd_data_b  <= '0;
            rd_valid_b <= 1'b0;
        end else begin
            rd_valid_a <= tap_a_s.valid;
            rd_valid_b <= tap_b_s.valid;
            if (tap_a_s.valid && !tap_a_s.keep) begin
                rd_data_a <= tap_a_s.data;
            end
            if (tap_b_s.valid && !tap_b_s.keep) begin
                rd_data_b <= tap_b_s.data;
            end
        end
    end

endmodule

// File: tb/tb_bram_tdp_ram_be.sv
// Bench for bram_tdp_ram_be: three instances with different read latencies
// and write modes share one stimulus stream and are compared every cycle
// against a transaction-level reference model.
module tb_bram_tdp_ram_be;

    localparam int DEPTH = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_a, en_b;
    logic [3:0]  we_a, we_b;
    logic [9:0]  addr_a, addr_b;
    logic [31:0] wd_a, wd_b;

    logic [31:0] rda [3];
    logic [31:0] rdb [3];
    logic        rva [3];
    logic        rvb [3];
    logic        col [3];

    always #5 clk = ~clk;

    bram_tdp_ram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MEM_DEPTH(DEPTH), .ADDR_WIDTH(10),
                      .RD_LATENCY(1), .WRITE_MODE_A(0), .WRITE_MODE_B(1)) u_d0 (
        .clk_a(clk), .reset(reset),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .wr_data_a(wd_a), .rd_data_a(rda[0]), .rd_valid_a(rva[0]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .wr_data_b(wd_b), .rd_data_b(rdb[0]), .rd_valid_b(rvb[0]),
        .collision(col[0]));

    bram_tdp_ram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MEM_DEPTH(DEPTH), .ADDR_WIDTH(10),
                      .RD_LATENCY(2), .WRITE_MODE_A(1), .WRITE_MODE_B(2)) u_d1 (
        .clk_a(clk), .reset(reset),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .wr_data_a(wd_a), .rd_data_a(rda[1]), .rd_valid_a(rva[1]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .wr_data_b(wd_b), .rd_data_b(rdb[1]), .rd_valid_b(rvb[1]),
        .collision(col[1]));

    bram_tdp_ram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MEM_DEPTH(DEPTH), .ADDR_WIDTH(10),
                      .RD_LATENCY(3), .WRITE_MODE_A(2), .WRITE_MODE_B(0)) u_d2 (
        .clk_a(clk), .reset(reset),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .wr_data_a(wd_a), .rd_data_a(rda[2]), .rd_valid_a(rva[2]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .wr_data_b(wd_b), .rd_data_b(rdb[2]), .rd_valid_b(rvb[2]),
        .collision(col[2]));

    // Reference model state
    int          lat    [3] = '{1, 2, 3};
    int          mode_p [3][2] = '{'{0, 1}, '{1, 2}, '{2, 0}};
    logic [31:0] ref_mem [1024];
    bit          sv [3][2][8];
    bit          sk [3][2][8];
    logic [31:0] sd [3][2][8];
    bit          m_valid [3][2];
    logic [31:0] m_data  [3][2];
    bit          m_col;
    int          ncyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs just sampled.
    task automatic model_edge();
        logic        e  [2];
        logic [3:0]  w  [2];
        logic [9:0]  a  [2];
        logic [31:0] dw [2];
        logic [31:0] old [2];
        int          s;
        if (reset) begin
            for (int d = 0; d < 3; d++)
                for (int p = 0; p < 2; p++) begin
                    for (int k = 0; k < 8; k++) sv[d][p][k] = 1'b0;
                    m_valid[d][p] = 1'b0;
                    m_data[d][p]  = 32'h0;
                end
            m_col = 1'b0;
        end else begin
            e[0] = en_a; w[0] = we_a; a[0] = addr_a; dw[0] = wd_a;
            e[1] = en_b; w[1] = we_b; a[1] = addr_b; dw[1] = wd_b;
            for (int p = 0; p < 2; p++) old[p] = (a[p] < 10'(DEPTH)) ? ref_mem[a[p]] : 32'h0;
            for (int d = 0; d < 3; d++)
                for (int p = 0; p < 2; p++)
                    if (e[p]) begin
                        s = (ncyc + lat[d] - 1) % 8;
                        sv[d][p][s] = 1'b1;
                        sk[d][p][s] = (mode_p[d][p] == 2) && (w[p] != 4'h0);
                        if (a[p] >= 10'(DEPTH)) sd[d][p][s] = 32'h0;
                        else if (mode_p[d][p] == 1) sd[d][p][s] = lanes(old[p], dw[p], w[p]);
                        else sd[d][p][s] = old[p];
                    end
            m_col = e[0] && e[1] && (a[0] == a[1]) && (a[0] < 10'(DEPTH)) && ((w[0] & w[1]) != 4'h0);
            if (e[1] && a[1] < 10'(DEPTH)) ref_mem[a[1]] = lanes(ref_mem[a[1]], dw[1], w[1]);
            if (e[0] && a[0] < 10'(DEPTH)) ref_mem[a[0]] = lanes(ref_mem[a[0]], dw[0], w[0]);
            s = ncyc % 8;
            for (int d = 0; d < 3; d++)
                for (int p = 0; p < 2; p++) begin
                    m_valid[d][p] = sv[d][p][s];
                    if (sv[d][p][s] && !sk[d][p][s]) m_data[d][p] = sd[d][p][s];
                    sv[d][p][s] = 1'b0;
                end
        end
        ncyc++;
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("d%0d rd_valid_a c%0d", d, ncyc), 32'(rva[d]), 32'(m_valid[d][0]));
            check_eq($sformatf("d%0d rd_data_a c%0d",  d, ncyc), rda[d], m_data[d][0]);
            check_eq($sformatf("d%0d rd_valid_b c%0d", d, ncyc), 32'(rvb[d]), 32'(m_valid[d][1]));
            check_eq($sformatf("d%0d rd_data_b c%0d",  d, ncyc), rdb[d], m_data[d][1]);
            check_eq($sformatf("d%0d collision c%0d",  d, ncyc), 32'(col[d]), 32'(m_col));
        end
    endtask

    // One clock cycle: drive inputs, let the edge happen, update model, compare.
    task automatic cyc(input logic ea, input logic [3:0] wa, input logic [9:0] aa, input logic [31:0] da,
                       input logic eb, input logic [3:0] wb, input logic [9:0] ab, input logic [31:0] db,
                       input logic rst);
        en_a = ea; we_a = wa; addr_a = aa; wd_a = da;
        en_b = eb; we_b = wb; addr_b = ab; wd_b = db;
        reset = rst;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0);
    endtask

    function automatic logic [31:0] preload(input int k);
        if (k == 7) return 32'h11223344;
        if (k == 3) return 32'h0;
        return 32'(k) * 32'h0000_0101;
    endfunction

    initial begin
        logic [9:0]  ra, rb;
        logic [3:0]  rwa, rwb;

        cyc(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1);
        cyc(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1);
        check_eq("reset rd_data_a", rda[2], 32'h0);
        check_eq("reset rd_valid_a", 32'(rva[1]), 32'h0);

        // Preload addresses 0..15, two per cycle
        for (int k = 0; k < 16; k += 2)
            cyc(1'b1, 4'hF, 10'(k), preload(k), 1'b1, 4'hF, 10'(k + 1), preload(k + 1), 1'b0);
        idle(3);

        // Full-word write, then read on both ports; latency-2 instance checked explicitly
        cyc(1'b1, 4'hF, 10'd5, 32'hDEADBEEF, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0);
        idle(1);
        cyc(1'b1, 4'h0, 10'd5, 32'h0, 1'b1, 4'h0, 10'd5, 32'h0, 1'b0);
        check_eq("lat2 valid not early", 32'(rva[1]), 32'h0);
        idle(1);
        check_eq("lat2 valid at 2", 32'(rva[1]), 32'h1);
        check_eq("lat2 data a", rda[1], 32'hDEADBEEF);
        check_eq("lat2 data b", rdb[1], 32'hDEADBEEF);
        idle(2);

        // Partial byte-enable write
        cyc(1'b1, 4'h5, 10'd7, 32'hAABBCCDD, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0);
        cyc(1'b1, 4'h0, 10'd7, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0);
        idle(3);
        for (int d = 0; d < 3; d++) check_eq($sformatf("partial d%0d", d), rda[d], 32'h11BB33DD);

        // Write-mode behaviour at addr 3 (holds 0); prior rd_data_a is 0xCAFE
        cyc(1'b1, 4'hF, 10'd4, 32'h0000CAFE, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0);
        cyc(1'b1, 4'h0, 10'd4, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0);
        idle(3);
        cyc(1'b1, 4'hF, 10'd3, 32'h00000055, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0);
        idle(2);
        check_eq("nochange valid", 32'(rva[2]), 32'h1);
        check_eq("nochange data", rda[2], 32'h0000CAFE);
        idle(1);
        check_eq("readfirst data", rda[0], 32'h0);
        check_eq("writefirst data", rda[1], 32'h00000055);

        // Same-address write collision, then disjoint lanes (no collision)
        cyc(1'b1, 4'h1, 10'd9, 32'h000000AA, 1'b1, 4'h3, 10'd9, 32'h0000BB00, 1'b0);
        check_eq("collision pulse", 32'(col[0]), 32'h1);
        cyc(1'b1, 4'h1, 10'd10, 32'h000000AA, 1'b1, 4'h2, 10'd10, 32'h0000BB00, 1'b0);
        check_eq("collision one cycle", 32'(col[2]), 32'h0);
        idle(1);
        check_eq("disjoint no collision", 32'(col[1]), 32'h0);
        cyc(1'b1, 4'h0, 10'd9, 32'h0, 1'b1, 4'h0, 10'd10, 32'h0, 1'b0);
        idle(3);
        check_eq("collision merge", rda[0], 32'h0000BBAA);
        check_eq("disjoint merge", rdb[2], 32'h0000BBAA);

        // Out-of-range: write dropped, read returns zero with a valid pulse
        cyc(1'b1, 4'hF, 10'd1010, 32'h12345678, 1'b1, 4'h0, 10'd1010, 32'h0, 1'b0);
        check_eq("oor read b", rdb[0], 32'h0);
        cyc(1'b1, 4'h0, 10'd1010, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0);
        check_eq("oor read a", rda[0], 32'h0);
        check_eq("oor valid a", 32'(rva[0]), 32'h1);
        idle(3);

        // Back-to-back reads on both ports with random non-colliding writes
        for (int i = 0; i < 64; i++) begin
            ra  = 10'(i % 16);
            rb  = 10'($urandom_range(15));
            rwa = ($urandom_range(2) == 0) ? 4'($urandom_range(15, 1)) : 4'h0;
            rwb = ($urandom_range(2) == 0) ? 4'($urandom_range(15, 1)) : 4'h0;
            if (ra == rb && (rwa & rwb) != 4'h0) rwb = 4'h0;
            cyc(1'b1, rwa, ra, $urandom, 1'b1, rwb, rb, $urandom, 1'b0);
        end
        idle(3);

        // Reset with reads in flight; a write attempted during reset is ignored
        cyc(1'b1, 4'h0, 10'd0, 32'h0, 1'b1, 4'h0, 10'd1, 32'h0, 1'b0);
        cyc(1'b1, 4'h0, 10'd2, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0);
        cyc(1'b1, 4'hF, 10'd0, 32'hFFFFFFFF, 1'b1, 4'hF, 10'd1, 32'hFFFFFFFF, 1'b1);
        check_eq("rst lat3 valid a", 32'(rva[2]), 32'h0);
        check_eq("rst lat3 data a", rda[2], 32'h0);
        cyc(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1);
        idle(1);
        check_eq("post rst lat3 valid a", 32'(rva[2]), 32'h0);
        check_eq("post rst lat3 valid b", 32'(rvb[2]), 32'h0);
        idle(1);
        check_eq("post rst lat3 quiet", 32'(rva[2]), 32'h0);
        cyc(1'b1, 4'h0, 10'd0, 32'h0, 1'b1, 4'h0, 10'd1, 32'h0, 1'b0);
        cyc(1'b1, 4'h0, 10'd2, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
